fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the pipelined RV32I core; sits directly upstream of decode/immediate generation.
- Owns the PC and issues requests to instruction memory over a valid-based request/response handshake with variable latency.
- Presents {pc, pc+4, instruction, valid} to decode.
- Honours hazard-unit stalls and EX-stage redirects (taken branch, JAL, JALR).

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven on if_id_inst when invalid.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold IF/ID contents, accept no new instruction into decode.
- redirect  in  1  EX stage: control transfer taken this cycle.
- redirect_pc  in  32  target PC, sampled when redirect=1; bits[1:0] are zero by contract.
- imem_req  out  1  request strobe, one cycle per request.
- imem_addr  out  32  request address, valid when imem_req=1.
- imem_rdata  in  32  instruction word, valid when imem_valid=1.
- imem_valid  in  1  response strobe; at least 1 cycle after its request; in-order; at most one outstanding request.
- if_id_pc  out  32  PC of the decode-stage instruction.
- if_id_pc4  out  32  if_id_pc + 4, modulo 2^32.
- if_id_inst  out  32  instruction to decode; NOP_INST when if_id_valid=0.
- if_id_valid  out  1  decode slot holds a real instruction.

Behaviour:
- Reset (rst=1 at edge):
  - pc<=RESET_PC; state<=FETCH.
  - if_id_valid<=0, if_id_inst<=NOP_INST, if_id_pc<=0, if_id_pc4<=0; held register cleared.
  - Reset mid-operation abandons any outstanding request; the memory is reset with the core.
- Internal registers: pc (address of next/outstanding fetch); held_inst (32b skid); state in {FETCH, WAIT, HELD, KILL}.
- FETCH:
  - If redirect=0: imem_req=1, imem_addr=pc; next state WAIT.
  - If redirect=1: no request; pc<=redirect_pc; stay in FETCH.
- WAIT (request to pc outstanding):
  - redirect=1 and imem_valid=1: drop response; pc<=redirect_pc; go to FETCH.
  - redirect=1 and imem_valid=0: pc<=redirect_pc; go to KILL.
  - imem_valid=1 and stall=0 (chaining): load IF/ID with {pc, pc+4, imem_rdata, 1}. In the same cycle drive imem_req=1, imem_addr=pc+4; pc<=pc+4; stay in WAIT. With 1-cycle memory this gives 1 instruction per cycle.
  - imem_valid=1 and stall=1: held_inst<=imem_rdata; go to HELD; no request.
  - imem_valid=0: stay in WAIT.
- HELD:
  - redirect=1: discard held_inst; pc<=redirect_pc; go to FETCH.
  - stall=0: load IF/ID with {pc, pc+4, held_inst, 1}; pc<=pc+4; go to FETCH.
  - Otherwise stay in HELD.
- KILL (stale request outstanding):
  - imem_req=0.
  - On imem_valid, discard the response and go to FETCH.
  - A further redirect updates pc and stays in KILL.
- imem_valid outside WAIT/KILL is ignored.
- IF/ID register priority, highest first:
  1. rst.
  2. redirect: flush to if_id_valid=0, if_id_inst=NOP_INST; pc fields don't-care, held at previous values. Redirect beats stall.
  3. stall: hold all IF/ID fields.
  4. New instruction delivered: load.
  5. Otherwise: bubble (valid=0, inst=NOP_INST).
- Arithmetic: all pc+4 wrap modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- imem_req is never asserted while a request is outstanding, or in the cycle a response is discarded.

Test Plan:
- Reset: rst high 2 cycles, then low. First cycle after reset imem_req=1, imem_addr=0x0000_0000; if_id_valid=0; if_id_inst=0x0000_0013.
- Streaming, 1-cycle memory returning 0x00500093, 0x00A00113, 0x002081B3 for addrs 0x0, 0x4, 0x8. On consecutive cycles if_id_pc=0x0/0x4/0x8, if_id_pc4=0x4/0x8/0xC, matching inst, valid=1; imem_addr steps by 4 every cycle.
- Stall: 1-cycle memory, assert stall 3 cycles as the response for 0x8 arrives. IF/ID holds the 0x4 instruction; no imem_req during the stall. Releasing stall delivers 0x8 next edge; then a request for 0xC is issued.
- Redirect in WAIT: 3-cycle memory, redirect=1, redirect_pc=0x100 one cycle after the request for 0x10. The 0x10 response is discarded; if_id_valid=0; the next imem_req has addr 0x100; the 0x100 instruction appears with if_id_pc=0x100.
- Redirect and stall together, IF/ID holding a valid inst at 0x20: if_id_valid=0 next cycle; next request addr = redirect_pc (0x40).
- Wrap-around: redirect_pc=0xFFFF_FFFC, 1-cycle memory. if_id_pc4=0x0000_0000; the next imem_addr is 0x0000_0000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, talks to instruction memory over a valid-based request/response
// handshake (at most one request outstanding, in-order responses), and hands
// {pc, pc+4, inst, valid} to decode. Honours decode stalls and EX redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid
);

  // FETCH: free to issue; WAIT: request to pc outstanding;
  // HELD: response captured while decode was stalled;
  // KILL: a stale request is outstanding and its response must be dropped.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HELD  = 2'd2,
    KILL  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] held_inst_q, held_inst_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic [31:0] if_id_inst_q, if_id_inst_d;
  logic        if_id_valid_q, if_id_valid_d;

  logic [31:0] pc_plus4;
  logic        deliver;
  logic [31:0] deliver_inst;

  // Wraps modulo 2^32 naturally from the 32-bit width.
  assign pc_plus4 = pc_q + 32'd4;

  // Next-state, PC update and memory request generation.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    held_inst_d  = held_inst_q;
    imem_req     = 1'b0;
    imem_addr    = pc_q;
    deliver      = 1'b0;
    deliver_inst = imem_rdata;
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end else begin
          imem_req  = 1'b1;
          imem_addr = pc_q;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          // The in-flight fetch is on the wrong path.
          pc_d    = redirect_pc;
          state_d = imem_valid ? FETCH : KILL;
        end else if (imem_valid) begin
          if (!stall) begin
            // Chain the next request in the same cycle for 1 IPC with a
            // single-cycle memory.
            deliver      = 1'b1;
            deliver_inst = imem_rdata;
            imem_req     = 1'b1;
            imem_addr    = pc_plus4;
            pc_d         = pc_plus4;
          end else begin
            held_inst_d = imem_rdata;
            state_d     = HELD;
          end
        end
      end
      HELD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = FETCH;
        end else if (!stall) begin
          deliver      = 1'b1;
          deliver_inst = held_inst_q;
          pc_d         = pc_plus4;
          state_d      = FETCH;
        end
      end
      KILL: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (imem_valid) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // IF/ID register next value: redirect flush beats stall hold beats load.
  always_comb begin
    if_id_pc_d    = if_id_pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_inst_d  = NOP_INST;
    if_id_valid_d = 1'b0;
    if (redirect) begin
      if_id_inst_d  = NOP_INST;
      if_id_valid_d = 1'b0;
    end else if (stall) begin
      if_id_inst_d  = if_id_inst_q;
      if_id_valid_d = if_id_valid_q;
    end else if (deliver) begin
      if_id_pc_d    = pc_q;
      if_id_pc4_d   = pc_plus4;
      if_id_inst_d  = deliver_inst;
      if_id_valid_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      held_inst_q   <= 32'd0;
      if_id_pc_q    <= 32'd0;
      if_id_pc4_q   <= 32'd0;
      if_id_inst_q  <= NOP_INST;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      held_inst_q   <= held_inst_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign if_id_pc    = if_id_pc_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_inst  = if_id_inst_q;
  assign if_id_valid = if_id_valid_q;

endmodule
